// File: rtl/pmbist_march_ctrl.sv
// March C- sequencer for PMBIST: one memory op per cycle, pipelined read compare, sticky fail.
// Optional first-failure logging (fail_addr/fail_elem) enabled by defining PMBIST_FAIL_LOG_EN.
module pmbist_march_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [2:0]        elem,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef PMBIST_FAIL_LOG_EN
  ,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ZERO = '0;

  // E3/E4 walk the address space downwards
  function automatic logic down_f(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  function automatic logic single_f(input logic [2:0] e);
    return (e == 3'd0) || (e == 3'd5);
  endfunction

  function automatic logic rd_f(input logic [2:0] e, input logic op);
    return (e != 3'd0) && !op;
  endfunction

  // Background bit for the op: expected value on reads, written value on writes
  function automatic logic bg_f(input logic [2:0] e, input logic op);
    if (rd_f(e, op)) return (e == 3'd2) || (e == 3'd4);
    return (e == 3'd1) || (e == 3'd3);
  endfunction

  state_t              state_q, state_d;
  logic                op_q, op_d;
  logic [2:0]          elem_d;
  logic [ADDR_W-1:0]   addr_d;
  logic                en_d, we_d, busy_d, done_d, fail_d;
  logic [DATA_W-1:0]   wdata_d;
  logic                cmp_v_q, cmp_v_d;
  logic [DATA_W-1:0]   exp_q, exp_d;
`ifdef PMBIST_FAIL_LOG_EN
  logic [ADDR_W-1:0]   cmp_addr_q, cmp_addr_d, flog_addr_d;
  logic [2:0]          cmp_elem_q, cmp_elem_d, flog_elem_d;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    elem_d  = elem;
    addr_d  = mem_addr;
    busy_d  = busy;
    done_d  = done;
    fail_d  = fail;
    cmp_v_d = 1'b0;
    exp_d   = exp_q;
    en_d    = 1'b0;
    we_d    = 1'b0;
    wdata_d = '0;
`ifdef PMBIST_FAIL_LOG_EN
    cmp_addr_d  = cmp_addr_q;
    cmp_elem_d  = cmp_elem_q;
    flog_addr_d = fail_addr;
    flog_elem_d = fail_elem;
`endif

    if (cmp_v_q && (mem_rdata != exp_q)) begin
      fail_d = 1'b1;
`ifdef PMBIST_FAIL_LOG_EN
      if (!fail) begin
        flog_addr_d = cmp_addr_q;
        flog_elem_d = cmp_elem_q;
      end
`endif
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          fail_d  = 1'b0;
          elem_d  = 3'd0;
          op_d    = 1'b0;
          addr_d  = ZERO;
`ifdef PMBIST_FAIL_LOG_EN
          flog_addr_d = ZERO;
          flog_elem_d = 3'd0;
`endif
        end
      end
      RUN: begin
        if (rd_f(elem, op_q)) begin
          cmp_v_d = 1'b1;
          exp_d   = {DATA_W{bg_f(elem, op_q)}};
`ifdef PMBIST_FAIL_LOG_EN
          cmp_addr_d = mem_addr;
          cmp_elem_d = elem;
`endif
        end
        if (!single_f(elem) && !op_q) begin
          op_d = 1'b1;
        end else if (mem_addr != (down_f(elem) ? ZERO : LAST)) begin
          op_d   = 1'b0;
          addr_d = down_f(elem) ? mem_addr - 1'b1 : mem_addr + 1'b1;
        end else if (elem == 3'd5) begin
          state_d = DRAIN;
          op_d    = 1'b0;
          addr_d  = ZERO;
        end else begin
          elem_d = elem + 3'd1;
          op_d   = 1'b0;
          addr_d = down_f(elem + 3'd1) ? LAST : ZERO;
        end
      end
      DRAIN: begin
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        elem_d  = 3'd0;
      end
      default: state_d = IDLE;
    endcase

    // Memory strobes are derived from the next cursor so they leave registered
    if (state_d == RUN) begin
      en_d    = 1'b1;
      we_d    = !rd_f(elem_d, op_d);
      wdata_d = we_d ? {DATA_W{bg_f(elem_d, op_d)}} : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      op_q      <= 1'b0;
      elem      <= '0;
      mem_addr  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
      cmp_v_q   <= 1'b0;
      exp_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      elem      <= elem_d;
      mem_addr  <= addr_d;
      mem_en    <= en_d;
      mem_we    <= we_d;
      mem_wdata <= wdata_d;
      busy      <= busy_d;
      done      <= done_d;
      fail      <= fail_d;
      cmp_v_q   <= cmp_v_d;
      exp_q     <= exp_d;
    end
  end

`ifdef PMBIST_FAIL_LOG_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmp_addr_q <= '0;
      cmp_elem_q <= '0;
      fail_addr  <= '0;
      fail_elem  <= '0;
    end else begin
      cmp_addr_q <= cmp_addr_d;
      cmp_elem_q <= cmp_elem_d;
      fail_addr  <= flog_addr_d;
      fail_elem  <= flog_elem_d;
    end
  end
`endif

endmodule

// File: tb/tb_pmbist_march_ctrl.sv
// Directed bench for pmbist_march_ctrl: DEPTH=4 and DEPTH=5/ADDR_W=3 instances with memory models.
module tb_pmbist_march_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start4 = 1'b0, start5 = 1'b0, fault = 1'b0;
  always #5 clk = ~clk;

  logic       busy4, done4, fail4, en4, we4;
  logic [2:0] elem4, fe4;
  logic [7:0] addr4, wd4, rd4, fa4;
  logic       busy5, done5, fail5, en5, we5;
  logic [2:0] elem5, fe5, addr5, fa5;
  logic [7:0] wd5, rd5;

  pmbist_march_ctrl #(.ADDR_W(8), .DATA_W(8), .DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .busy(busy4), .done(done4), .fail(fail4),
    .elem(elem4), .mem_en(en4), .mem_we(we4), .mem_addr(addr4), .mem_wdata(wd4),
    .mem_rdata(rd4)
`ifdef PMBIST_FAIL_LOG_EN
    , .fail_addr(fa4), .fail_elem(fe4)
`endif
  );

  pmbist_march_ctrl #(.ADDR_W(3), .DATA_W(8), .DEPTH(5)) dut5 (
    .clk(clk), .rst(rst), .start(start5), .busy(busy5), .done(done5), .fail(fail5),
    .elem(elem5), .mem_en(en5), .mem_we(we5), .mem_addr(addr5), .mem_wdata(wd5),
    .mem_rdata(rd5)
`ifdef PMBIST_FAIL_LOG_EN
    , .fail_addr(fa5), .fail_elem(fe5)
`endif
  );

`ifndef PMBIST_FAIL_LOG_EN
  assign fa4 = '0;
  assign fe4 = '0;
  assign fa5 = '0;
  assign fe5 = '0;
`endif

  // Single-port memories; dut4's can inject bit0 stuck-at-1 at address 2 on reads
  logic [7:0] mem4 [0:255];
  logic [7:0] mem5 [0:7];
  always @(posedge clk) begin
    if (en4 && we4) mem4[addr4] <= wd4;
    if (en4 && !we4) rd4 <= mem4[addr4] | ((fault && addr4 == 8'd2) ? 8'h01 : 8'h00);
    if (en5 && we5) mem5[addr5] <= wd5;
    if (en5 && !we5) rd5 <= mem5[addr5];
  end

  bit          sel;
  logic [23:0] obs, raw;
  logic [10:0] flog_obs;
  always_comb begin
    if (!sel) begin
      obs = {busy4, done4, fail4, en4, we4, elem4, addr4, (we4 ? wd4 : 8'h00)};
      raw = {busy4, done4, fail4, en4, we4, elem4, addr4, wd4};
      flog_obs = {fe4, fa4};
    end else begin
      obs = {busy5, done5, fail5, en5, we5, elem5, 5'd0, addr5, (we5 ? wd5 : 8'h00)};
      raw = {busy5, done5, fail5, en5, we5, elem5, 5'd0, addr5, wd5};
      flog_obs = {fe5, 5'd0, fa5};
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic       ex_we   [50];
  logic       ex_dat  [50];
  logic [2:0] ex_el   [50];
  logic [7:0] ex_addr [50];
  int         nops;

  task automatic put(input int e, input int a, input logic we, input logic dat);
    ex_el[nops]   = 3'(e);
    ex_addr[nops] = 8'(a);
    ex_we[nops]   = we;
    ex_dat[nops]  = dat;
    nops++;
  endtask

  // March C- reference trace written out element by element
  task automatic build(input int d);
    nops = 0;
    for (int e = 0; e < 6; e++)
      for (int i = 0; i < d; i++) begin
        int a;
        a = (e == 3 || e == 4) ? d - 1 - i : i;
        case (e)
          0: put(0, a, 1'b1, 1'b0);
          1: begin put(1, a, 1'b0, 1'b0); put(1, a, 1'b1, 1'b1); end
          2: begin put(2, a, 1'b0, 1'b1); put(2, a, 1'b1, 1'b0); end
          3: begin put(3, a, 1'b0, 1'b0); put(3, a, 1'b1, 1'b1); end
          4: begin put(4, a, 1'b0, 1'b1); put(4, a, 1'b1, 1'b0); end
          default: put(5, a, 1'b0, 1'b0);
        endcase
      end
  endtask

  task automatic run(input bit s, input int d, input int pulse_at, input int rst_at,
                     input int fail_cyc, input logic [7:0] fl_addr, input logic [2:0] fl_elem);
    logic        ef;
    logic [23:0] e;
    sel = s;
    build(d);
    @(negedge clk);
    if (!s) start4 = 1'b1; else start5 = 1'b1;
    for (int j = 1; j <= 10 * d + 2; j++) begin
      @(negedge clk);
      if (j == 1) begin start4 = 1'b0; start5 = 1'b0; end
      ef = (fail_cyc != 0) && (j >= fail_cyc);
      if (j == rst_at) begin
        rst = 1'b0;
        #1;
        chk("rst_mid", {8'd0, raw}, 32'd0);
        chk("rst_mid_flog", {21'd0, flog_obs}, 32'd0);
        @(negedge clk);
        chk("rst_idle", {8'd0, raw}, 32'd0);
        return;
      end
      if (j == 1) chk("flog_clr", {21'd0, flog_obs}, 32'd0);
      if (j <= 10 * d) begin
        e = {1'b1, 1'b0, ef, 1'b1, ex_we[j-1], ex_el[j-1], ex_addr[j-1],
             (ex_we[j-1] ? {8{ex_dat[j-1]}} : 8'h00)};
        chk($sformatf("op%0d", j - 1), {8'd0, obs}, {8'd0, e});
      end else if (j == 10 * d + 1) begin
        chk("drain", {28'd0, obs[23:20]}, {28'd0, 1'b1, 1'b0, ef, 1'b0});
      end else begin
        chk("done", {28'd0, obs[23:20]}, {28'd0, 1'b0, 1'b1, ef, 1'b0});
`ifdef PMBIST_FAIL_LOG_EN
        chk("flog", {21'd0, flog_obs}, {21'd0, fl_elem, fl_addr});
`endif
      end
      if (j == pulse_at) begin if (!s) start4 = 1'b1; else start5 = 1'b1; end
      if (j == pulse_at + 1) begin start4 = 1'b0; start5 = 1'b0; end
    end
  endtask

  initial begin
    #2;
    sel = 1'b0; #1 chk("rst4", {8'd0, raw}, 32'd0);
    chk("rst4_flog", {21'd0, flog_obs}, 32'd0);
    sel = 1'b1; #1 chk("rst5", {8'd0, raw}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run(1'b0, 4, 0, 0, 0, 8'd0, 3'd0);
    fault = 1'b1;
    run(1'b0, 4, 0, 0, 11, 8'd2, 3'd1);
    fault = 1'b0;
    run(1'b0, 4, 10, 0, 0, 8'd0, 3'd0);
    run(1'b0, 4, 0, 20, 0, 8'd0, 3'd0);
    @(negedge clk);
    rst = 1'b1;
    run(1'b0, 4, 0, 0, 0, 8'd0, 3'd0);
    run(1'b1, 5, 0, 0, 0, 8'd0, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pmbist_march_ctrl.md
# pmbist_march_ctrl

March-test sequencer for the programmable memory BIST. Drives one single-port synchronous memory under test through a fixed March C- algorithm: it generates address, write data, enable and write-enable, one operation per cycle. It compares pipelined read data against the expected background and reports a sticky pass/fail. Sits between the BIST top-level start/status registers and the memory wrapper.

## Interface
- `ADDR_W`, 8, memory address width
- `DATA_W`, 8, memory data width
- `DEPTH`, 256, number of words tested, 2 ≤ DEPTH ≤ 2**ADDR_W; addresses 0..DEPTH-1
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-low reset; clears all state
- `start`  in  1  begin test; sampled only in IDLE or DONE
- `busy`  out  1  high in RUN and DRAIN
- `done`  out  1  high in DONE, held until next accepted start
- `fail`  out  1  sticky mismatch flag, cleared on accepted start
- `elem`  out  3  current march element 0..5 (0 when idle)
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  1 = write, 0 = read (valid when mem_en)
- `mem_addr`  out  ADDR_W  access address
- `mem_wdata`  out  DATA_W  write data, all-0 or all-1
- `mem_rdata`  in  DATA_W  read data, valid one cycle after read issued
- `fail_addr`  out  ADDR_W  first failing address (PMBIST_FAIL_LOG_EN only)
- `fail_elem`  out  3  element of first failure (PMBIST_FAIL_LOG_EN only)

## Operation
- Elements, in order:
  - E0 ⇑(w0)
  - E1 ⇑(r0,w1)
  - E2 ⇑(r1,w0)
  - E3 ⇓(r0,w1)
  - E4 ⇓(r1,w0)
  - E5 ⇑(r0)
- ⇑ runs addr 0→DEPTH-1; ⇓ runs addr DEPTH-1→0. "0" is all zeros and "1" is all ones across DATA_W.
- FSM states: IDLE → (start) RUN → (last op of E5 at last address) DRAIN → DONE → (start) RUN.
- RUN issues exactly one operation per cycle: mem_en=1, no bubbles, including across element boundaries.
- Op index steps through the element's ops at each address, then the address advances. At the last address of an element, control moves to the next element's first op and start address.
- Reads: expected value and a compare-valid bit are registered with the read. On the next cycle, if mem_rdata ≠ expected, fail is set. fail stays set; the test does not abort.
- DRAIN is a single cycle: mem_en=0, last compare of E5 performed.
- start while busy: ignored.
- start in DONE: clears done and fail, restarts at E0 addr 0.
- Reset values, all outputs: busy=0, done=0, fail=0, elem=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, fail_addr=0, fail_elem=0. State = IDLE.
- Reset mid-run returns to IDLE immediately. No partial status is retained, and the pending compare is discarded.
- Address counter width is ADDR_W. Terminal detection compares against DEPTH-1 or 0, never relying on wrap-around.

## Timing
- start high at edge k (in IDLE/DONE): first operation (E0 w0, addr 0) presented in cycle k+1; busy=1 from k+1.
- RUN lasts 10·DEPTH cycles. DRAIN is cycle k+10·DEPTH+1. done=1 and busy=0 from cycle k+10·DEPTH+2.
- Compare latency is fixed at 1 cycle. fail rises in the cycle after the corresponding mem_rdata is sampled, i.e. 2 cycles after the read is issued.
- elem changes in the same cycle as the first operation of the new element.
- All outputs are registered.

## Configuration
- `PMBIST_FAIL_LOG_EN` defined:
  - fail_addr and fail_elem ports exist.
  - On the first mismatch after a start, they capture the address and element of the failing read.
  - They are frozen by later mismatches and cleared to 0 on accepted start.
- Not defined: those ports and registers are absent; only the fail flag is reported.

## Test plan
- DEPTH=4, fault-free memory model, start pulse at cycle 0:
  - Operation trace matches March C- exactly: 40 ops, E3/E4 addresses 3,2,1,0.
  - done rises at cycle 42; fail=0.
- DEPTH=4, bit0 of addr 2 stuck-at-1: fail=1 at done. With PMBIST_FAIL_LOG_EN: fail_addr=2, fail_elem=1 (first r0 after w0).
- Start pulsed again at cycle 10 of a run: ignored. Trace unchanged, done still at cycle 42.
- rst asserted at cycle 20 mid-run: all outputs 0 immediately, state IDLE. A later start produces a full clean 42-cycle run.
- After a failing run, start from DONE: fail and done clear next cycle. A run on a fault-free memory ends with fail=0.
- DEPTH=5, ADDR_W=3 (non-power-of-two): addresses never exceed 4; ⇓ elements begin at 4; done at cycle 52.
